// File: rtl/prga_fifo_rr_arbiter.sv
// Round-robin arbiter merging NUM_SRC lookahead FIFO read interfaces into one
// lookahead read interface. A grant is held for up to BURST_MAX words; each
// output word carries the index of the source it came from.
module prga_fifo_rr_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_SRC      = 4,
  parameter int SRC_ID_WIDTH = 2,
  parameter int BURST_MAX    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              empty_i,
  output logic [NUM_SRC-1:0]              rd_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   dout_i,
  output logic                            empty,
  input  logic                            rd,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic [SRC_ID_WIDTH-1:0]         src_id
);

  localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t                  state, state_next;
  logic [SRC_ID_WIDTH-1:0] ptr, grant, found_id, grant_inc;
  logic                    found;
  logic [CNT_W-1:0]        count;
  logic                    valid, load_ok, grant_empty, xfer, last_word, release_grant;

  // Round-robin scan: first non-empty source starting at ptr
  always_comb begin
    found    = 1'b0;
    found_id = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!found && !empty_i[(32'(ptr) + i) % NUM_SRC]) begin
        found    = 1'b1;
        found_id = SRC_ID_WIDTH'((32'(ptr) + i) % NUM_SRC);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = BURST;
      BURST:   if (release_grant) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs and transfer control; rd_i is forced low while rst is asserted
  // so no source is popped during the reset cycle.
  always_comb begin
    grant_empty   = empty_i[grant];
    load_ok       = !valid || rd;
    xfer          = (state == BURST) && !grant_empty && load_ok && !rst;
    last_word     = (count == CNT_W'(BURST_MAX - 1));
    release_grant = grant_empty || (xfer && last_word);
    grant_inc     = (grant == SRC_ID_WIDTH'(NUM_SRC - 1)) ? '0 : grant + SRC_ID_WIDTH'(1);
    empty         = !valid;
    rd_i          = '0;
    if (xfer) rd_i[grant] = 1'b1;
  end

  // Grant, pointer and burst counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      grant <= '0;
      count <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        grant <= found_id;
        count <= '0;
      end
    end else begin
      // Counter is cleared on release so it never exceeds BURST_MAX-1.
      if (release_grant) begin
        ptr   <= grant_inc;
        count <= '0;
      end else if (xfer) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // One-entry output register: load on transfer, otherwise drain on pop
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      dout   <= '0;
      src_id <= '0;
    end else if (xfer) begin
      valid  <= 1'b1;
      dout   <= dout_i[grant*DATA_WIDTH +: DATA_WIDTH];
      src_id <= grant;
    end else if (rd) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prga_fifo_rr_arbiter.sv
// Self-checking bench for prga_fifo_rr_arbiter: source FIFOs are modelled as
// queues, output words are checked against per-source expected queues, and
// the source order is predicted from the round-robin/burst rules.
module tb_prga_fifo_rr_arbiter;

  localparam int DW = 8;
  localparam int NS = 4;
  localparam int IW = 2;
  localparam int BM = 4;

  logic              clk;
  logic              rst;
  logic [NS-1:0]     empty_i;
  logic [NS-1:0]     rd_i;
  logic [NS*DW-1:0]  dout_i;
  logic              empty;
  logic              rd;
  logic [DW-1:0]     dout;
  logic [IW-1:0]     src_id;

  prga_fifo_rr_arbiter #(
    .DATA_WIDTH(DW), .NUM_SRC(NS), .SRC_ID_WIDTH(IW), .BURST_MAX(BM)
  ) dut (
    .clk(clk), .rst(rst), .empty_i(empty_i), .rd_i(rd_i), .dout_i(dout_i),
    .empty(empty), .rd(rd), .dout(dout), .src_id(src_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] srcq [NS][$];
  logic [DW-1:0] expq [NS][$];
  int            obs_src [$];
  int            obs_time [$];
  int            exp_seq [$];
  int            cnt [NS];
  int            step_no = 0;
  logic [NS-1:0] last_ri;
  logic          held;
  logic [DW-1:0] held_dout;
  logic [IW-1:0] held_src;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int k, input logic [DW-1:0] d);
    srcq[k].push_back(d);
    expq[k].push_back(d);
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NS; k++) begin
      empty_i[k] = (srcq[k].size() == 0);
      dout_i[k*DW +: DW] = (srcq[k].size() != 0) ? srcq[k][0] : '0;
    end
  endtask

  // Drive inputs, let them settle and check protocol / output data
  task automatic tick_pre();
    drive_inputs();
    #1;
    check("rd_i_onehot0", 32'($onehot0(rd_i)), 1);
    check("rd_i_while_empty", 32'(rd_i & empty_i), 0);
    if (!rst && held) begin
      check("hold_dout", dout, held_dout);
      check("hold_src_id", src_id, held_src);
    end
    if (!rst && rd && !empty) begin
      obs_src.push_back(int'(src_id));
      obs_time.push_back(step_no);
      check("word_available", expq[src_id].size() > 0, 1);
      if (expq[src_id].size() > 0) check("data", dout, expq[src_id].pop_front());
    end
    held      = !rst && !empty && !rd;
    held_dout = dout;
    held_src  = src_id;
  endtask

  // Advance one clock; sources pop on the rd_i seen just before the edge
  task automatic tick_post();
    last_ri = rd_i;
    @(posedge clk);
    for (int k = 0; k < NS; k++)
      if (last_ri[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
    step_no++;
    @(negedge clk);
  endtask

  task automatic tick();
    tick_pre();
    tick_post();
  endtask

  // After reset only words still held by the sources can appear
  task automatic resync();
    for (int k = 0; k < NS; k++) expq[k] = srcq[k];
    obs_src.delete();
    obs_time.delete();
    held = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rd  = 1'b0;
    tick();
    rst = 1'b0;
    resync();
  endtask

  // Expected source order when all sources are preloaded and not refilled
  function automatic void build_order();
    int rem [NS];
    int p, total, k, n;
    exp_seq.delete();
    total = 0;
    for (int i = 0; i < NS; i++) begin
      rem[i] = cnt[i];
      total += cnt[i];
    end
    p = 0;
    while (total > 0) begin
      k = p;
      for (int i = 0; i < NS; i++) begin
        k = (p + i) % NS;
        if (rem[k] > 0) break;
      end
      n = (rem[k] < BM) ? rem[k] : BM;
      for (int j = 0; j < n; j++) exp_seq.push_back(k);
      rem[k] -= n;
      total  -= n;
      p = (k + 1) % NS;
    end
  endfunction

  task automatic check_order(input string tag);
    check({tag, "_len"}, obs_src.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < obs_src.size(); i++)
      check(tag, obs_src[i], exp_seq[i]);
  endtask

  task automatic drain(input int rand_rd, input int maxc);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < maxc) begin
      rd = rand_rd ? ($urandom_range(2) == 0) : 1'b1;
      tick();
      n++;
      done = empty;
      for (int k = 0; k < NS; k++) if (srcq[k].size() != 0) done = 1'b0;
    end
    check("drain_done", done, 1);
    for (int k = 0; k < NS; k++) check("no_loss", expq[k].size(), 0);
  endtask

  initial begin
    int t0;
    int nxt;
    int pat4 [9];
    rst     = 1'b1;
    rd      = 1'b0;
    empty_i = '1;
    dout_i  = '0;
    held    = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    drive_inputs();
    #1;
    check("rst_empty", empty, 1);
    check("rst_dout", dout, 0);
    check("rst_src_id", src_id, 0);
    check("rst_rd_i", rd_i, 0);
    tick_post();

    // 1: single source, three words, first-word latency
    rd = 1'b1;
    tick();
    push_word(0, 8'h11);
    push_word(0, 8'h22);
    push_word(0, 8'h33);
    t0 = step_no;
    drain(0, 40);
    cnt = '{3, 0, 0, 0};
    build_order();
    check_order("t1_order");
    if (obs_time.size() == 3) begin
      check("t1_first_latency", obs_time[0] - t0, 2);
      check("t1_second", obs_time[1] - t0, 3);
      check("t1_third", obs_time[2] - t0, 4);
    end else check("t1_count", obs_time.size(), 3);

    // 2: all sources six words, rd held high
    do_reset();
    for (int k = 0; k < NS; k++)
      for (int j = 0; j < 6; j++) push_word(k, 8'((k << 4) | j));
    drain(0, 200);
    cnt = '{6, 6, 6, 6};
    build_order();
    check_order("t2_order");
    for (int n = 1; n < 16 && n < obs_time.size(); n++)
      check("t2_burst_gap", obs_time[n] - obs_time[0], n + n / BM);

    // 3: same load, random consumer pops
    do_reset();
    for (int k = 0; k < NS; k++)
      for (int j = 0; j < 6; j++) push_word(k, 8'((k << 4) | j));
    drain(1, 600);
    build_order();
    check_order("t3_order");

    // 4: src0 always refilled, src2 one word
    do_reset();
    nxt = 0;
    push_word(2, 8'hA0);
    rd = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (srcq[0].size() < 2) begin
        push_word(0, 8'(nxt));
        nxt++;
      end
      tick();
    end
    pat4 = '{0, 0, 0, 0, 2, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++)
      check("t4_order", (i < obs_src.size()) ? obs_src[i] : 99, pat4[i]);
    drain(0, 60);

    // 5: reset on the second word of a burst from src1
    do_reset();
    for (int j = 0; j < 6; j++) push_word(1, 8'(8'h50 + j));
    rd = 1'b1;
    tick();
    tick();
    drive_inputs();
    #1;
    check("t5_second_word_rd_i", rd_i, 4'b0010);
    rst = 1'b1;
    #1;
    check("t5_rst_cycle_rd_i", rd_i, 0);
    tick_post();
    rst = 1'b0;
    resync();
    push_word(0, 8'h01);
    push_word(0, 8'h02);
    tick_pre();
    check("t5_after_rst_empty", empty, 1);
    check("t5_after_rst_rd_i", rd_i, 0);
    tick_post();
    drain(0, 80);
    cnt = '{2, 5, 0, 0};
    build_order();
    check_order("t5_order");

    // 6: pops while everything is empty
    do_reset();
    rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick_pre();
      check("t6_rd_i", rd_i, 0);
      check("t6_empty", empty, 1);
      check("t6_dout", dout, 0);
      check("t6_src_id", src_id, 0);
      tick_post();
    end

    // Random preloads with random consumer
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int k = 0; k < NS; k++) begin
        cnt[k] = $urandom_range(9);
        for (int j = 0; j < cnt[k]; j++) push_word(k, 8'($urandom));
      end
      build_order();
      drain(1, 800);
      check_order("rand_order");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
